// File: rtl/turn_scheduler.sv
// Blackjack round sequencer: deals the opening cards, grants the turn to one player at a time, runs the dealer draw loop.
// All outputs are registered; each card request is held until it is acknowledged. TURN_TIMEOUT_EN enables auto-stand of idle players.
module turn_scheduler #(
  parameter int NUM_PLAYERS    = 2,
  parameter int DEALER_STAND   = 17,
  parameter int TIMEOUT_CYCLES = 45000000
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_dealButtonPushed,
  input  logic [NUM_PLAYERS-1:0]             i_ready,
  input  logic [2*NUM_PLAYERS-1:0]           i_command,
  input  logic [NUM_PLAYERS-1:0]             i_bust,
  input  logic [4:0]                         i_dealerScore,
  input  logic                               i_cardAck,
  output logic [NUM_PLAYERS-1:0]             o_turnIndicator,
  output logic                               o_cardReq,
  output logic [$clog2(NUM_PLAYERS+1)-1:0]   o_cardDest,
  output logic                               o_clearHands,
  output logic                               o_dealerTurn,
  output logic                               o_roundDone,
  output logic                               o_timeout
);

  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int DW = $clog2(NUM_PLAYERS + 1);
  localparam logic [3:0] NP1       = 4'(NUM_PLAYERS + 1);
  localparam logic [3:0] DEAL_LAST = 4'(2 * NUM_PLAYERS + 1);
  localparam logic [4:0] STAND_V   = 5'(DEALER_STAND);
  localparam logic [1:0] CMD_HIT   = 2'd1;
  localparam logic [1:0] CMD_STAND = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_INIT_DEAL,
    S_SETTLE,
    S_PLAYER,
    S_PLAYER_WAIT,
    S_DEALER,
    S_DEALER_WAIT,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   player_idx, p_n;
  logic [3:0]      deal_cnt, deal_n;
  logic            to_dealer, to_dealer_n;
  logic            req_n;
  logic [DW-1:0]   dest_n;
  logic [NUM_PLAYERS-1:0] turn_n;
  logic [1:0]      cmd;
  logic            adv;
  logic            auto_stand;
  logic            timed_out;

  always_comb begin
    state_n     = state;
    p_n         = player_idx;
    deal_n      = deal_cnt;
    to_dealer_n = to_dealer;
    req_n       = o_cardReq;
    dest_n      = o_cardDest;
    adv         = 1'b0;
    auto_stand  = 1'b0;
    cmd         = i_command[2*int'(player_idx) +: 2];

    case (state)
      S_IDLE, S_DONE: begin
        if (i_dealButtonPushed) state_n = S_CLEAR;
      end
      S_CLEAR: begin
        deal_n  = '0;
        state_n = S_INIT_DEAL;
      end
      S_INIT_DEAL: begin
        if (!o_cardReq) begin
          req_n  = 1'b1;
          dest_n = (deal_cnt >= NP1) ? DW'(deal_cnt - NP1) : DW'(deal_cnt);
        end else if (i_cardAck) begin
          req_n  = 1'b0;
          deal_n = deal_cnt + 4'd1;
          if (deal_cnt == DEAL_LAST) begin
            state_n     = S_SETTLE;
            p_n         = '0;
            to_dealer_n = 1'b0;
          end
        end
      end
      S_SETTLE: begin
        state_n = to_dealer ? S_DEALER : S_PLAYER;
      end
      S_PLAYER: begin
        // Bust beats any command; reserved/NONE commands are no-ops.
        if (i_bust[player_idx]) begin
          adv = 1'b1;
        end else if (i_ready[player_idx]) begin
          if (cmd == CMD_STAND) begin
            adv = 1'b1;
          end else if (cmd == CMD_HIT) begin
            state_n = S_PLAYER_WAIT;
            req_n   = 1'b1;
            dest_n  = DW'(player_idx);
          end
        end else if (timed_out) begin
          adv        = 1'b1;
          auto_stand = 1'b1;
        end
        if (adv) begin
          if (player_idx == PW'(NUM_PLAYERS - 1)) state_n = S_DEALER;
          else                                    p_n     = player_idx + PW'(1);
        end
      end
      S_PLAYER_WAIT: begin
        if (o_cardReq && i_cardAck) begin
          req_n       = 1'b0;
          state_n     = S_SETTLE;
          to_dealer_n = 1'b0;
        end
      end
      S_DEALER: begin
        if (&i_bust) begin
          state_n = S_DONE;
        end else if (i_dealerScore < STAND_V) begin
          state_n = S_DEALER_WAIT;
          req_n   = 1'b1;
          dest_n  = DW'(NUM_PLAYERS);
        end else begin
          state_n = S_DONE;
        end
      end
      S_DEALER_WAIT: begin
        if (o_cardReq && i_cardAck) begin
          req_n       = 1'b0;
          state_n     = S_SETTLE;
          to_dealer_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    turn_n = '0;
    if (state_n == S_PLAYER) turn_n[p_n] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state           <= S_IDLE;
      player_idx      <= '0;
      deal_cnt        <= '0;
      to_dealer       <= 1'b0;
      o_cardReq       <= 1'b0;
      o_cardDest      <= '0;
      o_turnIndicator <= '0;
      o_clearHands    <= 1'b0;
      o_dealerTurn    <= 1'b0;
      o_roundDone     <= 1'b0;
    end else begin
      state           <= state_n;
      player_idx      <= p_n;
      deal_cnt        <= deal_n;
      to_dealer       <= to_dealer_n;
      o_cardReq       <= req_n;
      o_cardDest      <= dest_n;
      o_turnIndicator <= turn_n;
      o_clearHands    <= (state_n == S_CLEAR);
      o_dealerTurn    <= (state_n == S_DEALER) || (state_n == S_DEALER_WAIT);
      o_roundDone     <= (state_n == S_DONE);
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt;

  assign timed_out = (state == S_PLAYER) && (to_cnt >= TO_LAST);

  // Restarts for each new turn and on any button press of the active player.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      to_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= auto_stand;
      if (state == S_PLAYER) begin
        if (i_ready[player_idx] || state_n != S_PLAYER || p_n != player_idx)
          to_cnt <= '0;
        else
          to_cnt <= to_cnt + 32'd1;
      end else if (state_n == S_PLAYER) begin
        to_cnt <= '0;
      end
    end
  end
`else
  logic unused_cfg;
  assign timed_out  = 1'b0;
  assign o_timeout  = 1'b0;
  assign unused_cfg = ^{32'(TIMEOUT_CYCLES), auto_stand};
`endif

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler: opening deal, hit/stand play, bust skip, stray inputs, mid-deal reset, optional timeout.
module tb_turn_scheduler;
  localparam int N = 2;

  logic             clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_dealButtonPushed = 1'b0;
  logic [N-1:0]     i_ready = '0;
  logic [2*N-1:0]   i_command = '0;
  logic [N-1:0]     i_bust = '0;
  logic [4:0]       i_dealerScore = 5'd12;
  logic             i_cardAck = 1'b0;
  logic [N-1:0]     o_turnIndicator;
  logic             o_cardReq;
  logic [1:0]       o_cardDest;
  logic             o_clearHands;
  logic             o_dealerTurn;
  logic             o_roundDone;
  logic             o_timeout;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int clear_cnt = 0;
  logic req_prev = 1'b0;
  int base;

  turn_scheduler #(.NUM_PLAYERS(N), .DEALER_STAND(17), .TIMEOUT_CYCLES(100)) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_dealButtonPushed(i_dealButtonPushed),
    .i_ready(i_ready),
    .i_command(i_command),
    .i_bust(i_bust),
    .i_dealerScore(i_dealerScore),
    .i_cardAck(i_cardAck),
    .o_turnIndicator(o_turnIndicator),
    .o_cardReq(o_cardReq),
    .o_cardDest(o_cardDest),
    .o_clearHands(o_clearHands),
    .o_dealerTurn(o_dealerTurn),
    .o_roundDone(o_roundDone),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  // Passive tally of request rising edges and clear-pulse cycles.
  always @(negedge clk) begin
    if (o_cardReq && !req_prev) req_cnt++;
    if (o_clearHands) clear_cnt++;
    req_prev = o_cardReq;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve_card(input string tag, input int exp_dest);
    int n = 0;
    while (!o_cardReq && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_req"}, o_cardReq, 1);
    check({tag, "_dest"}, o_cardDest, exp_dest);
    repeat (2) tick();
    i_cardAck = 1'b1;
    tick();
    i_cardAck = 1'b0;
    check({tag, "_drop"}, o_cardReq, 0);
  endtask

  task automatic press(input logic [N-1:0] rdy, input logic [2*N-1:0] cmd);
    i_ready   = rdy;
    i_command = cmd;
    tick();
    i_ready   = '0;
    i_command = '0;
  endtask

  task automatic start_round(input string tag);
    int c0 = clear_cnt;
    i_dealButtonPushed = 1'b1;
    tick();
    i_dealButtonPushed = 1'b0;
    check({tag, "_clear"}, o_clearHands, 1);
    for (int k = 0; k < 2 * (N + 1); k++) serve_card(tag, k % (N + 1));
    tick();
    check({tag, "_turn0"}, o_turnIndicator, 2'b01);
    check({tag, "_clear_once"}, clear_cnt - c0, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_roundDone && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_done"}, o_roundDone, 1);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_turn", o_turnIndicator, 0);
    check("rst_req", o_cardReq, 0);
    check("rst_dest", o_cardDest, 0);
    check("rst_clear", o_clearHands, 0);
    check("rst_dlr", o_dealerTurn, 0);
    check("rst_done", o_roundDone, 0);
    check("rst_to", o_timeout, 0);
    i_reset = 1'b0;
    tick();

    // Round 1: stray inputs, P0 hit then stand, P1 stand, one dealer draw.
    start_round("r1");
    base = req_cnt;
    i_ready = 2'b10;
    i_command = 4'b0100;
    tick();
    i_cardAck = 1'b1;
    tick();
    i_cardAck = 1'b0;
    tick();
    i_ready = '0;
    i_command = '0;
    check("stray_req", o_cardReq, 0);
    check("stray_cnt", req_cnt - base, 0);
    check("stray_turn", o_turnIndicator, 2'b01);
    i_dealButtonPushed = 1'b1;
    tick();
    i_dealButtonPushed = 1'b0;
    check("deal_ignored", o_clearHands, 0);

    press(2'b01, 4'b0001);
    check("hit_turn_off", o_turnIndicator, 0);
    serve_card("hit0", 0);
    tick();
    check("hit_back_p0", o_turnIndicator, 2'b01);
    press(2'b01, 4'b0010);
    check("p1_turn", o_turnIndicator, 2'b10);
    press(2'b10, 4'b1000);
    check("dlr_turn", o_dealerTurn, 1);
    check("dlr_noturn", o_turnIndicator, 0);
    base = req_cnt;
    serve_card("dlr", 2);
    i_dealerScore = 5'd18;
    wait_done("r1");
    check("r1_dlr_reqs", req_cnt - base, 1);
    check("r1_dlr_off", o_dealerTurn, 0);

    // Round 2: bust skips P0's stand; all bust means no dealer draw.
    i_dealerScore = 5'd12;
    start_round("r2");
    press(2'b01, 4'b0001);
    serve_card("hit_bust", 0);
    i_bust = 2'b01;
    tick();
    check("bust_recheck", o_turnIndicator, 2'b01);
    tick();
    check("bust_skip", o_turnIndicator, 2'b10);
    i_bust = 2'b11;
    base = req_cnt;
    wait_done("r2");
    check("r2_dlr_reqs", req_cnt - base, 0);
    i_bust = 2'b00;

    // Reset while a deal request is pending.
    i_dealButtonPushed = 1'b1;
    tick();
    i_dealButtonPushed = 1'b0;
    begin
      int n = 0;
      while (!o_cardReq && n < 20) begin
        tick();
        n++;
      end
    end
    check("mid_req", o_cardReq, 1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("mr_req", o_cardReq, 0);
    check("mr_done", o_roundDone, 0);
    check("mr_turn", o_turnIndicator, 0);
    check("mr_clear", o_clearHands, 0);
    base = req_cnt;
    i_cardAck = 1'b1;
    tick();
    i_cardAck = 1'b0;
    repeat (4) tick();
    check("mr_idle_req", req_cnt - base, 0);
    check("mr_idle_clear", o_clearHands, 0);
    check("mr_idle_dlr", o_dealerTurn, 0);

`ifdef TURN_TIMEOUT_EN
    start_round("r3");
    begin
      int n = 0;
      while (!o_timeout && n < 200) begin
        tick();
        n++;
      end
      check("to_cycle", n, 100);
    end
    check("to_turn", o_turnIndicator, 2'b10);
    tick();
    check("to_pulse_end", o_timeout, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
